lcd_sequencer: RTL and testbench

LCD_SEQUENCER -- requirements
Module: lcd_sequencer

---
 rtl/lcd_sequencer.sv | 119 +++++++++++
 tb/tb_lcd_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_sequencer.sv
// lcd_sequencer: power-up delay, LCD init commands and buffered 2x16 screen refresh
module lcd_sequencer #(
    parameter logic [15:0] INIT_DELAY   = 16'd50000,
    parameter logic        AUTO_REFRESH = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       refresh_req,
    output logic       ready,
    output logic       busy,
    output logic [7:0] lcd_data,
    output logic       lcd_is_cmd,
    output logic       lcd_req,
    input  logic       lcd_ack
);
    localparam logic [2:0] POWER    = 3'd0;
    localparam logic [2:0] INIT_REQ = 3'd1;
    localparam logic [2:0] INIT_REL = 3'd2;
    localparam logic [2:0] IDLE     = 3'd3;
    localparam logic [2:0] REF_REQ  = 3'd4;
    localparam logic [2:0] REF_REL  = 3'd5;
    logic [2:0]  state;
    logic [15:0] dly_cnt;
    logic [5:0]  idx;
    logic [5:0]  nxt;
    logic        pending;
    logic        init_done;
    logic        start_ref;
    logic [7:0]  char_buf [32];
    logic [4:0]  ref_sel;
    logic [7:0]  init_nxt;
    logic [7:0]  ref_nxt;
    assign nxt       = idx + 6'd1;
    assign init_done = state == INIT_REL && !lcd_ack && idx == 6'd3;
    assign start_ref = pending && (state == IDLE || init_done);
    assign busy      = !(state == IDLE && !pending);
    assign init_nxt  = nxt == 6'd1 ? 8'h0C : nxt == 6'd2 ? 8'h01 : 8'h06;
    // indices 1-16 map to buf[0..15], indices 18-33 to buf[16..31]
    assign ref_sel   = 5'(nxt - (nxt < 6'd17 ? 6'd1 : 6'd2));
    assign ref_nxt   = nxt == 6'd17 ? 8'hC0 : char_buf[ref_sel];
    // character buffer, writable in every state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) char_buf[i] <= 8'h20;
        end else if (wr_en) begin
            char_buf[wr_addr] <= wr_data;
        end
    end
    // sequencer: power-up wait, init commands, refresh transactions and pending tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= POWER;
            dly_cnt    <= 16'd0;
            idx        <= 6'd0;
            pending    <= 1'b0;
            ready      <= 1'b0;
            lcd_req    <= 1'b0;
            lcd_data   <= 8'h00;
            lcd_is_cmd <= 1'b1;
        end else begin
            pending <= start_ref ? 1'b0 : pending | refresh_req | (AUTO_REFRESH & wr_en);
            ready   <= ready | init_done;
            if (start_ref) begin
                state      <= REF_REQ;
                idx        <= 6'd0;
                lcd_req    <= 1'b1;
                lcd_data   <= 8'h80;
                lcd_is_cmd <= 1'b1;
            end else begin
                case (state)
                    POWER: begin
                        if (dly_cnt == INIT_DELAY - 16'd1) begin
                            state      <= INIT_REQ;
                            idx        <= 6'd0;
                            lcd_req    <= 1'b1;
                            lcd_data   <= 8'h38;
                            lcd_is_cmd <= 1'b1;
                        end else begin
                            dly_cnt <= dly_cnt + 16'd1;
                        end
                    end
                    INIT_REQ, REF_REQ: begin
                        if (lcd_ack) begin
                            lcd_req <= 1'b0;
                            state   <= state == INIT_REQ ? INIT_REL : REF_REL;
                        end
                    end
                    INIT_REL: begin
                        if (init_done) begin
                            state <= IDLE;
                        end else if (!lcd_ack) begin
                            state      <= INIT_REQ;
                            idx        <= nxt;
                            lcd_req    <= 1'b1;
                            lcd_data   <= init_nxt;
                            lcd_is_cmd <= 1'b1;
                        end
                    end
                    REF_REL: begin
                        if (!lcd_ack && idx == 6'd33) begin
                            state <= IDLE;
                        end else if (!lcd_ack) begin
                            state      <= REF_REQ;
                            idx        <= nxt;
                            lcd_req    <= 1'b1;
                            lcd_data   <= ref_nxt;
                            lcd_is_cmd <= nxt == 6'd17;
                        end
                    end
                    IDLE: ;
                    default: state <= POWER;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lcd_sequencer.sv
// tb_lcd_sequencer: directed tests of init, refresh, handshake and reset behaviour
module tb_lcd_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [4:0] wr_addr = 5'd0;
    logic [7:0] wr_data = 8'd0;
    logic       refresh_req = 1'b0;
    logic       lcd_ack = 1'b0;
    logic       ready, busy, lcd_is_cmd, lcd_req;
    logic [7:0] lcd_data;
    int         tests = 0;
    int         fails = 0;
    int         ack_hold = 0;
    int         ack_cnt = 0;
    int         rise_err = 0;
    int         stab_err = 0;
    logic       prev_req = 1'b0;
    logic [8:0] prev_tx = 9'd0;
    logic [8:0] txq [$];

    always #5 clk = ~clk;

    lcd_sequencer #(.INIT_DELAY(16'd10), .AUTO_REFRESH(1'b1)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .refresh_req(refresh_req), .ready(ready), .busy(busy), .lcd_data(lcd_data),
        .lcd_is_cmd(lcd_is_cmd), .lcd_req(lcd_req), .lcd_ack(lcd_ack)
    );

    // LCD model: logs each transaction, flags protocol violations, acks 3 cycles after a request
    always @(posedge clk) begin
        #2;
        if (lcd_req && !prev_req) begin
            txq.push_back({lcd_is_cmd, lcd_data});
            if (lcd_ack) rise_err++;
        end
        if (lcd_req && prev_req && {lcd_is_cmd, lcd_data} !== prev_tx) stab_err++;
        prev_req = lcd_req;
        prev_tx  = {lcd_is_cmd, lcd_data};
        if (rst) begin
            lcd_ack = 1'b0;
            ack_cnt = 0;
        end else if (!lcd_ack) begin
            ack_cnt = lcd_req ? ack_cnt + 1 : 0;
            if (ack_cnt >= 3) begin
                lcd_ack = 1'b1;
                ack_cnt = 0;
            end
        end else if (!lcd_req) begin
            if (ack_cnt >= ack_hold) begin
                lcd_ack = 1'b0;
                ack_cnt = 0;
            end else begin
                ack_cnt++;
            end
        end
    end

    task automatic wait_ready(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_tx(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (txq.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_refresh();
        @(negedge clk) refresh_req = 1'b1;
        @(negedge clk) refresh_req = 1'b0;
    endtask

    // counts refresh entries that differ from a blank screen except the two given characters
    function automatic int ref_errors(input int base, input logic [7:0] c1, input logic [7:0] c19);
        int e = 0;
        logic [8:0] exp;
        for (int i = 0; i < 34; i++) begin
            exp = i == 0 ? 9'h180 : i == 17 ? 9'h1C0 : i == 1 ? {1'b0, c1} : i == 19 ? {1'b0, c19} : 9'h020;
            if (base + i >= txq.size() || txq[base + i] !== exp) e++;
        end
        return e;
    endfunction

    task automatic test_reset();
        int n;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (lcd_req !== 1'b0 || ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: lcd_req=%b ready=%b, required 0 0", lcd_req, ready);
        end
        tests++;
        if (lcd_data !== 8'h00 || lcd_is_cmd !== 1'b1) begin
            fails++;
            $display("FAIL reset_data: lcd_data=%h lcd_is_cmd=%b, required 00 1", lcd_data, lcd_is_cmd);
        end
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_busy: busy=%b, required 1", busy);
        end
        txq.delete();
        rst = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_after_release: busy=%b, required 1", busy);
        end
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (lcd_req === 1'b1) begin
                n = i;
                break;
            end
        end
        tests++;
        if (n != 10) begin
            fails++;
            $display("FAIL first_req_delay: got %0d cycles, required 10", n);
        end
    endtask

    task automatic test_init();
        bit ok;
        int e = 0;
        logic [8:0] exp [4] = '{9'h138, 9'h10C, 9'h101, 9'h106};
        wait_ready(400, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL init_ready: ready=%b, required 1 within 400 cycles", ready);
        end
        for (int i = 0; i < 4; i++) if (i >= txq.size() || txq[i] !== exp[i]) e++;
        tests++;
        if (txq.size() != 4 || e != 0) begin
            fails++;
            $display("FAIL init_cmds: %0d transactions with %0d wrong, required 4 with 0 wrong", txq.size(), e);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL init_busy: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_write_refresh();
        bit ok;
        int e;
        txq.delete();
        @(negedge clk) begin wr_en = 1'b1; wr_addr = 5'd0; wr_data = 8'h48; end
        @(negedge clk) begin wr_addr = 5'd17; wr_data = 8'h69; end
        @(negedge clk) wr_en = 1'b0;
        wait_idle(4000, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL write_ref_done: busy=%b, required 0 within 4000 cycles", busy);
        end
        e = ref_errors(0, 8'h48, 8'h69);
        tests++;
        if (txq.size() != 34 || e != 0) begin
            fails++;
            $display("FAIL write_ref_data: %0d transactions with %0d wrong, required 34 with 0 wrong", txq.size(), e);
        end
        repeat (100) @(negedge clk);
        tests++;
        if (txq.size() != 34) begin
            fails++;
            $display("FAIL write_ref_count: got %0d transactions, required 34", txq.size());
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int e;
        txq.delete();
        pulse_refresh();
        wait_tx(6, 1000, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL b2b_index5: got %0d transactions, required 6", txq.size());
        end
        pulse_refresh();
        wait_idle(8000, ok);
        tests++;
        if (!ok || txq.size() != 68) begin
            fails++;
            $display("FAIL b2b_no_gap: %0d transactions at first idle, required 68", txq.size());
        end
        e = ref_errors(34, 8'h48, 8'h69);
        tests++;
        if (e != 0) begin
            fails++;
            $display("FAIL b2b_second_data: %0d wrong entries, required 0", e);
        end
        repeat (200) @(negedge clk);
        tests++;
        if (txq.size() != 68) begin
            fails++;
            $display("FAIL b2b_no_third: got %0d transactions, required 68", txq.size());
        end
    endtask

    task automatic test_ack_hold();
        bit ok;
        ack_hold = 4;
        rise_err = 0;
        stab_err = 0;
        txq.delete();
        pulse_refresh();
        wait_idle(10000, ok);
        tests++;
        if (!ok || txq.size() != 34) begin
            fails++;
            $display("FAIL hold_count: got %0d transactions, required 34", txq.size());
        end
        tests++;
        if (rise_err != 0) begin
            fails++;
            $display("FAIL hold_req_during_ack: got %0d early requests, required 0", rise_err);
        end
        tests++;
        if (stab_err != 0) begin
            fails++;
            $display("FAIL hold_data_stable: got %0d changes during request, required 0", stab_err);
        end
        repeat (10) @(negedge clk);
        ack_hold = 0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int e = 0;
        logic [8:0] exp [4] = '{9'h138, 9'h10C, 9'h101, 9'h106};
        txq.delete();
        pulse_refresh();
        wait_tx(13, 2000, ok);
        rst = 1'b1;
        #1;
        tests++;
        if (!ok || lcd_req !== 1'b0 || ready !== 1'b0) begin
            fails++;
            $display("FAIL midreset_drop: lcd_req=%b ready=%b, required 0 0", lcd_req, ready);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_ready(400, ok);
        for (int i = 0; i < 4; i++) if (13 + i >= txq.size() || txq[13 + i] !== exp[i]) e++;
        tests++;
        if (!ok || e != 0) begin
            fails++;
            $display("FAIL midreset_reinit: %0d wrong init commands, required 0", e);
        end
        repeat (300) @(negedge clk);
        tests++;
        if (txq.size() != 17 || busy !== 1'b0) begin
            fails++;
            $display("FAIL midreset_no_refresh: %0d transactions busy=%b, required 17 0", txq.size(), busy);
        end
        txq.delete();
        pulse_refresh();
        wait_idle(4000, ok);
        e = ref_errors(0, 8'h20, 8'h20);
        tests++;
        if (!ok || txq.size() != 34 || e != 0) begin
            fails++;
            $display("FAIL midreset_blank_buf: %0d transactions with %0d wrong, required 34 with 0 wrong", txq.size(), e);
        end
    endtask

    task automatic test_power_pending();
        bit ok;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        txq.delete();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        pulse_refresh();
        wait_idle(4000, ok);
        tests++;
        if (!ok || txq.size() != 38) begin
            fails++;
            $display("FAIL power_pending_count: %0d transactions at first idle, required 38", txq.size());
        end
        tests++;
        if (txq.size() < 5 || txq[3] !== 9'h106 || txq[4] !== 9'h180) begin
            fails++;
            $display("FAIL power_pending_order: init end or refresh start wrong, required 106 then 180");
        end
        tests++;
        if (ready !== 1'b1) begin
            fails++;
            $display("FAIL power_pending_ready: ready=%b, required 1", ready);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_write_refresh();
        test_back_to_back();
        test_ack_hold();
        test_reset_mid();
        test_power_pending();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
